// File: rtl/envelope_adsr_pkg.sv
// Shared constants, state encoding and helpers for the ADSR envelope.
// Depths live here so the top and the bench agree on widths.
package envelope_adsr_pkg;

  localparam int OSC_DEPTH = 16;
  localparam int ENV_DEPTH = 8;

  localparam logic [ENV_DEPTH-1:0] ENV_MAX = '1;

  typedef enum logic [2:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_DECAY,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_e;

  // A zero rate would stall the envelope forever, so it steps by one.
  function automatic logic [ENV_DEPTH-1:0] eff_rate(
    input logic [ENV_DEPTH-1:0] r
  );
    return (r == '0) ? ENV_DEPTH'(1) : r;
  endfunction

endpackage

// File: rtl/envelope_adsr_tick.sv
// Free-running prescaler; tick is high for the one cycle the counter
// is all-ones, giving a period of 2^PRESCALE clocks.
module env_tick #(
  parameter int PRESCALE = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [PRESCALE-1:0] cnt_q, cnt_d;

  assign cnt_d = cnt_q + PRESCALE'(1);
  assign tick  = &cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/envelope_adsr.sv
// ADSR envelope generator scaling an oscillator sample by the level.
// Define ENV_RETRIGGER_EN to re-attack from the current release level.
module envelope_adsr
  import envelope_adsr_pkg::*;
#(
  parameter int PRESCALE = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gate,
  input  logic [OSC_DEPTH-1:0] v,
  input  logic [ENV_DEPTH-1:0] atk_rate,
  input  logic [ENV_DEPTH-1:0] dec_rate,
  input  logic [ENV_DEPTH-1:0] rel_rate,
  input  logic [ENV_DEPTH-1:0] sus_level,
  output logic [OSC_DEPTH-1:0] vo,
  output logic [ENV_DEPTH-1:0] level,
  output logic                 active
);

  localparam int PW = OSC_DEPTH + ENV_DEPTH;

  env_state_e           state_q, state_d;
  logic [ENV_DEPTH-1:0] level_q, level_d;
  logic [OSC_DEPTH-1:0] vo_q, vo_d;
  logic                 active_q, active_d;
  logic                 gate_q;
  logic                 tick, rise, fall;
  logic [ENV_DEPTH-1:0] atk, dec, rel;
  logic [ENV_DEPTH:0]   sum;
  logic [PW-1:0]        prod;

  env_tick #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;
  assign atk  = eff_rate(atk_rate);
  assign dec  = eff_rate(dec_rate);
  assign rel  = eff_rate(rel_rate);
  assign sum  = {1'b0, level_q} + {1'b0, atk};
  assign prod = {{ENV_DEPTH{1'b0}}, v} * {{OSC_DEPTH{1'b0}}, level_q};
  assign vo_d = prod[PW-1:ENV_DEPTH];

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      ENV_IDLE: begin
        level_d = '0;
        if (rise) state_d = ENV_ATTACK;
      end
      ENV_ATTACK: begin
        if (fall) begin
          state_d = ENV_RELEASE;
        end else if (tick) begin
          if (sum >= {1'b0, ENV_MAX}) begin
            level_d = ENV_MAX;
            state_d = ENV_DECAY;
          end else begin
            level_d = sum[ENV_DEPTH-1:0];
          end
        end
      end
      ENV_DECAY: begin
        if (fall) begin
          state_d = ENV_RELEASE;
        end else if (tick) begin
          if (level_q <= sus_level ||
              (level_q - sus_level) <= dec) begin
            level_d = sus_level;
            state_d = ENV_SUSTAIN;
          end else begin
            level_d = level_q - dec;
          end
        end
      end
      ENV_SUSTAIN: begin
        level_d = sus_level;
        if (fall) begin
          level_d = level_q;
          state_d = ENV_RELEASE;
        end
      end
      ENV_RELEASE: begin
        if (rise) begin
          state_d = ENV_ATTACK;
`ifdef ENV_RETRIGGER_EN
          level_d = level_q;
`else
          level_d = '0;
`endif
        end else if (tick) begin
          if (level_q <= rel) begin
            level_d = '0;
            state_d = ENV_IDLE;
          end else begin
            level_d = level_q - rel;
          end
        end
      end
      default: begin
        state_d = ENV_IDLE;
        level_d = '0;
      end
    endcase
  end

  assign active_d = (state_d != ENV_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ENV_IDLE;
      level_q  <= '0;
      vo_q     <= '0;
      active_q <= 1'b0;
      gate_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      vo_q     <= vo_d;
      active_q <= active_d;
      gate_q   <= gate;
    end
  end

  assign vo     = vo_q;
  assign level  = level_q;
  assign active = active_q;

endmodule

// File: tb/tb_envelope_adsr.sv
// Directed bench for envelope_adsr at PRESCALE=2 (tick every 4 clocks).
// Expectations follow ENV_RETRIGGER_EN when it is defined.
module tb_envelope_adsr;
  import envelope_adsr_pkg::*;

`ifdef ENV_RETRIGGER_EN
  localparam int RT0 = 100;
  localparam int RT1 = 164;
  localparam int RT2 = 165;
`else
  localparam int RT0 = 0;
  localparam int RT1 = 64;
  localparam int RT2 = 65;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 gate = 1'b0;
  logic [OSC_DEPTH-1:0] v = '0;
  logic [ENV_DEPTH-1:0] atk_rate = '0;
  logic [ENV_DEPTH-1:0] dec_rate = '0;
  logic [ENV_DEPTH-1:0] rel_rate = '0;
  logic [ENV_DEPTH-1:0] sus_level = '0;
  logic [OSC_DEPTH-1:0] vo;
  logic [ENV_DEPTH-1:0] level;
  logic                 active;

  int total = 0;
  int bad = 0;
  int pc = 0;
  bit ticked = 1'b0;

  envelope_adsr #(.PRESCALE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .gate      (gate),
    .v         (v),
    .atk_rate  (atk_rate),
    .dec_rate  (dec_rate),
    .rel_rate  (rel_rate),
    .sus_level (sus_level),
    .vo        (vo),
    .level     (level),
    .active    (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Tracks the prescaler: an edge applies a tick when the count was 3.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      ticked = (!rst && pc == 3);
      if (rst) pc = 0;
      else     pc = (pc + 1) % 4;
    end
    #1;
  endtask

  task automatic tick_step();
    int k = 0;
    do begin
      step(1);
      k++;
    end while (!ticked && k < 8);
    if (!ticked) begin
      total++;
      bad++;
      $error("FAIL tick_wait: got none want tick");
    end
  endtask

  task automatic align();
    int k = 0;
    while (pc != 3 && k < 8) begin
      step(1);
      k++;
    end
  endtask

  initial begin
    rst = 1'b1;
    gate = 1'b0;
    v = 16'h8000;
    step(3);
    rst = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_vo", vo, 0);
    chk("rst_active", active, 0);

    atk_rate = 8'd64;
    dec_rate = 8'd16;
    sus_level = 8'd200;
    rel_rate = 8'd100;
    gate = 1'b1;
    step(1);
    chk("atk_active", active, 1);
    chk("atk_start", level, 0);
    tick_step(); chk("atk_64", level, 64);
    step(1);     chk("vo_64", vo, 8192);
    tick_step(); chk("atk_128", level, 128);
    step(1);     chk("vo_128", vo, 16384);
    tick_step(); chk("atk_192", level, 192);
    tick_step(); chk("atk_255", level, 255);
    tick_step(); chk("dec_239", level, 239);
    tick_step(); chk("dec_223", level, 223);
    tick_step(); chk("dec_207", level, 207);
    tick_step(); chk("dec_200", level, 200);
    sus_level = 8'd180;
    step(1);     chk("sus_180", level, 180);
    sus_level = 8'd200;
    step(1);     chk("sus_200", level, 200);

    gate = 1'b0;
    step(1);
    chk("rel_hold", level, 200);
    chk("rel_active", active, 1);
    tick_step(); chk("rel_100", level, 100);
    tick_step(); chk("rel_0", level, 0);
    chk("idle_active", active, 0);
    step(1);     chk("vo_0", vo, 0);

    gate = 1'b1;
    step(1);
    repeat (4) tick_step();
    chk("atk2_255", level, 255);
    dec_rate = 8'd255;
    tick_step(); chk("dec_clamp", level, 200);
    step(1);
    gate = 1'b0;
    step(1);
    tick_step(); chk("rel2_100", level, 100);
    align();
    gate = 1'b1;
    step(1);
    chk("retrig_edge", level, RT0);
    chk("retrig_active", active, 1);
    tick_step(); chk("retrig_tick", level, RT1);
    atk_rate = 8'd0;
    tick_step(); chk("atk_zero_rate", level, RT2);

    atk_rate = 8'd255;
    sus_level = 8'd255;
    tick_step(); chk("atk_sat", level, 255);
    tick_step(); chk("dec_sus_max", level, 255);
    sus_level = 8'd180;
    step(1);     chk("sus_max_exit", level, 180);

    rst = 1'b1;
    step(1);
    chk("midrst_level", level, 0);
    chk("midrst_vo", vo, 0);
    chk("midrst_active", active, 0);
    rst = 1'b0;
    step(1);
    chk("post_rst_active", active, 1);
    chk("post_rst_level", level, 0);
    tick_step(); chk("post_rst_atk", level, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/envelope_adsr.md
ENVELOPE_ADSR -- requirements
Module: envelope_adsr

Interface
REQ-001 SHALL have parameter PRESCALE, default 10: envelope tick period is 2^PRESCALE clk cycles.
REQ-002 SHALL have port clk  input  1: single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-004 SHALL have port gate  input  1: note held (1) / released (0), synchronous to clk.
REQ-005 SHALL have port v  input  `OSC_DEPTH: unsigned oscillator sample.
REQ-006 SHALL have ports atk_rate, dec_rate, rel_rate  input  `ENV_DEPTH each: level step per tick.
REQ-007 SHALL have port sus_level  input  `ENV_DEPTH: sustain level.
REQ-008 SHALL have port vo  output  `OSC_DEPTH: enveloped sample.
REQ-009 SHALL have port level  output  `ENV_DEPTH: current envelope level.
REQ-010 SHALL have port active  output  1: high whenever state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
REQ-012 SHALL generate a one-cycle tick when a free-running PRESCALE-bit counter is all-ones; level changes only on tick cycles.
REQ-013 SHALL treat any rate input of 0 as 1.
REQ-014 SHALL register gate each clk and detect rising/falling edges; edge-driven state changes take effect on the next clk edge, independent of tick.
REQ-015 IDLE: level 0; gate rising edge -> ATTACK.
REQ-016 ATTACK: per tick, level += atk_rate saturating at MAX = 2^`ENV_DEPTH-1; on reaching MAX -> DECAY.
REQ-017 DECAY: per tick, level -= dec_rate, clamped to sus_level; on reaching sus_level -> SUSTAIN; if sus_level = MAX, exit to SUSTAIN on the first tick.
REQ-018 SUSTAIN: level follows sus_level every clk, including mid-note changes.
REQ-019 Gate falling edge in ATTACK, DECAY or SUSTAIN SHALL enter RELEASE from the current level.
REQ-020 RELEASE: per tick, level -= rel_rate saturating at 0; on reaching 0 -> IDLE.
REQ-021 Gate edge and tick in the same cycle: the state change wins; no level step is applied that cycle.
REQ-022 vo SHALL equal (v * level) >> `ENV_DEPTH, registered, one clk latency; full-width product; no rounding.
REQ-023 active SHALL be registered, coincident with state.

Reset
REQ-024 rst high SHALL force state IDLE, level 0, vo 0, active 0, tick counter 0 and registered gate 0 on the next clk edge.
REQ-025 rst mid-note SHALL abort any state; after release of rst, a gate already held high SHALL register as a rising edge and start ATTACK.

Configuration
REQ-026 Macro ENV_RETRIGGER_EN defined: a gate rising edge in RELEASE SHALL enter ATTACK from the current level.
REQ-027 ENV_RETRIGGER_EN undefined: a gate rising edge in RELEASE SHALL force level to 0, then enter ATTACK.

Structure
REQ-028 `ENV_DEPTH (8) and state encodings `ENV_IDLE..`ENV_RELEASE SHALL be added to constants.v beside `OSC_DEPTH and `key_t.
REQ-029 The prescaler counter and tick SHALL be a sub-module env_tick (clk, rst, tick).

Verification (PRESCALE=2, tick every 4 clks, `ENV_DEPTH=8)
REQ-030 rst high for 3 clks, gate 0 -> level 0, vo 0, active 0, state IDLE.
REQ-031 gate 0->1, atk_rate 64 -> level 64, 128, 192, 255 on successive ticks; active high; then DECAY.
REQ-032 dec_rate 16, sus_level 200 -> 239, 223, 207, 200; then SUSTAIN. sus_level changed to 180 -> level 180 next clk.
REQ-033 gate 1->0, level 200, rel_rate 100 -> 100, 0; then IDLE; active low.
REQ-034 gate re-raised at RELEASE level 100 -> with ENV_RETRIGGER_EN next tick 164 (atk 64); without it level 0 then 64.
REQ-035 v = 2^(`OSC_DEPTH-1), level 128 -> vo = 2^(`OSC_DEPTH-2) one clk later; level 0 -> vo 0.
